// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter_if
//  Purpose  : Bundles the two requester byte streams and the UART transmitter
//             handshake around uart_tx_arbiter.
//  Ports    : req0_*/req1_*  valid/data/last from requesters, ready back
//             tx_start/tx_data/tx_busy  launch handshake with the transmitter
//             grant/err_timeout/byte_cnt  status outputs of the arbiter
//  Modports : slave  - arbiter view
//             master - environment view (requesters + transmitter)
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_last;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_last;
    logic        req1_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant;
    logic        err_timeout;
    logic [15:0] byte_cnt;

    modport slave (
        input  req0_valid, req0_data, req0_last,
        output req0_ready,
        input  req1_valid, req1_data, req1_last,
        output req1_ready,
        output tx_start, tx_data,
        input  tx_busy,
        output grant, err_timeout, byte_cnt
    );

    modport master (
        output req0_valid, req0_data, req0_last,
        input  req0_ready,
        output req1_valid, req1_data, req1_last,
        input  req1_ready,
        input  tx_start, tx_data,
        output tx_busy,
        input  grant, err_timeout, byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Arbitrates two byte requesters onto a single UART transmitter.
//             Round-robin between requesters, packet lock until a byte with
//             last=1, one byte in flight, tx_busy watchdog.
//  Ports    : clk     - clock, rising edge
//             resetn  - asynchronous active-low reset
//             bus     - uart_tx_arbiter_if.slave (requesters, transmitter,
//                       grant/err_timeout/byte_cnt status)
//  Params   : WD_MAX  - cycles to wait for tx_busy to rise after tx_start
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int unsigned WD_MAX = 16
) (
    input  wire logic         clk,
    input  wire logic         resetn,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned WD_W = (WD_MAX > 1) ? $clog2(WD_MAX) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic             lock_q,     lock_d;
    logic             lock_id_q,  lock_id_d;
    logic             rr_q,       rr_d;
    logic [7:0]       tx_data_q,  tx_data_d;
    logic [1:0]       grant_q,    grant_d;
    logic [15:0]      byte_cnt_q, byte_cnt_d;
    logic [WD_W-1:0]  wd_q,       wd_d;

    logic             sel_id;
    logic             sel_valid;
    logic [7:0]       sel_data;
    logic             sel_last;
    logic             xfer;
    logic             timeout;

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // A locked packet owns the arbiter even while its requester is idle.
    always_comb begin : p_select
        sel_id    = rr_q;
        sel_valid = 1'b0;
        if (lock_q) begin
            sel_id    = lock_id_q;
            sel_valid = lock_id_q ? bus.req1_valid : bus.req0_valid;
        end else if (bus.req0_valid && bus.req1_valid) begin
            sel_id    = rr_q;
            sel_valid = 1'b1;
        end else if (bus.req0_valid) begin
            sel_id    = 1'b0;
            sel_valid = 1'b1;
        end else if (bus.req1_valid) begin
            sel_id    = 1'b1;
            sel_valid = 1'b1;
        end
    end

    // resetn gates ready so nothing is accepted while reset is held.
    assign xfer     = resetn && (state_q == IDLE) && !bus.tx_busy && sel_valid;
    assign sel_data = sel_id ? bus.req1_data : bus.req0_data;
    assign sel_last = sel_id ? bus.req1_last : bus.req0_last;
    assign timeout  = (state_q == WAIT_BUSY) && !bus.tx_busy && (wd_q == WD_LAST);

    assign bus.req0_ready  = xfer && !sel_id;
    assign bus.req1_ready  = xfer &&  sel_id;
    assign bus.tx_start    = (state_q == LAUNCH);
    assign bus.tx_data     = tx_data_q;
    assign bus.grant       = grant_q;
    assign bus.err_timeout = timeout;
    assign bus.byte_cnt    = byte_cnt_q;

    always_comb begin : p_next
        state_d    = state_q;
        lock_d     = lock_q;
        lock_id_d  = lock_id_q;
        rr_d       = rr_q;
        tx_data_d  = tx_data_q;
        grant_d    = grant_q;
        byte_cnt_d = byte_cnt_q;
        wd_d       = wd_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    tx_data_d = sel_data;
                    grant_d   = onehot(sel_id);
                    state_d   = LAUNCH;
                    if (sel_last) begin
                        lock_d = 1'b0;
                        rr_d   = ~sel_id;
                    end else begin
                        lock_d    = 1'b1;
                        lock_id_d = sel_id;
                    end
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                    lock_d  = 1'b0;
                    grant_d = 2'b00;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_d    = IDLE;
                    byte_cnt_d = byte_cnt_q + 16'd1;
                    // Back in IDLE grant shows the packet owner, if any.
                    grant_d    = lock_q ? onehot(lock_id_q) : 2'b00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin : p_regs
        if (!resetn) begin
            state_q    <= IDLE;
            lock_q     <= 1'b0;
            lock_id_q  <= 1'b0;
            rr_q       <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= 2'b00;
            byte_cnt_q <= 16'h0000;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            lock_id_q  <= lock_id_d;
            rr_q       <= rr_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            byte_cnt_q <= byte_cnt_d;
            wd_q       <= wd_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_arbiter
//  Purpose  : Directed self-checking bench for uart_tx_arbiter with queue
//             driven requesters and a simple busy-pulse transmitter model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if bus ();

    uart_tx_arbiter #(.WD_MAX(16)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0]  q0[$];          // {last, data}
    logic [8:0]  q1[$];
    bit          busy_en  = 1'b1;
    int          busy_len = 10;
    int          busy_cnt = 0;

    logic [7:0]  tx_log[$];
    int          tx_cyc[$];
    logic [1:0]  tx_grant[$];
    int          err_cyc[$];
    int          rdy0_cnt = 0;
    int          rdy0_cyc = 0;
    bit          start_seen = 1'b0;
    bit          xf0 = 1'b0;
    bit          xf1 = 1'b0;

    // Monitor: everything is sampled on the falling edge.
    always @(negedge clk) begin
        cyc        = cyc + 1;
        start_seen = bus.tx_start;
        xf0        = bus.req0_valid & bus.req0_ready;
        xf1        = bus.req1_valid & bus.req1_ready;
        if (bus.tx_start) begin
            tx_log.push_back(bus.tx_data);
            tx_cyc.push_back(cyc);
            tx_grant.push_back(bus.grant);
        end
        if (bus.err_timeout) err_cyc.push_back(cyc);
        if (bus.req0_ready) begin
            rdy0_cnt = rdy0_cnt + 1;
            rdy0_cyc = cyc;
        end
    end

    // Requesters and transmitter model, updated just after each rising edge.
    initial begin
        bus.req0_valid = 1'b0; bus.req0_data = 8'h00; bus.req0_last = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_data = 8'h00; bus.req1_last = 1'b0;
        bus.tx_busy    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (xf0 && q0.size() > 0) q0.delete(0);
            if (xf1 && q1.size() > 0) q1.delete(0);
            xf0 = 1'b0;
            xf1 = 1'b0;
            if (start_seen && busy_en) busy_cnt = busy_len;
            else if (busy_cnt > 0)     busy_cnt = busy_cnt - 1;
            start_seen  = 1'b0;
            bus.tx_busy = busy_en && (busy_cnt > 0);
            bus.req0_valid = (q0.size() > 0);
            bus.req0_data  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
            bus.req0_last  = (q0.size() > 0) ? q0[0][8]   : 1'b0;
            bus.req1_valid = (q1.size() > 0);
            bus.req1_data  = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
            bus.req1_last  = (q1.size() > 0) ? q1[0][8]   : 1'b0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_logs();
        tx_log.delete(); tx_cyc.delete(); tx_grant.delete(); err_cyc.delete();
        rdy0_cnt = 0;
    endtask

    task automatic apply_reset();
        tick();
        resetn = 1'b0;
        q0.delete(); q1.delete();
        busy_en = 1'b1; busy_len = 10; busy_cnt = 0; bus.tx_busy = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        clear_logs();
    endtask

    task automatic wait_cnt(input logic [15:0] target, input int budget);
        int n = 0;
        while (bus.byte_cnt !== target && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_tx(input int count, input int budget);
        int n = 0;
        while (tx_log.size() < count && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        int rel;
        q0.push_back({1'b1, 8'hAA});
        repeat (3) tick();
        checks++; if (bus.tx_start !== 1'b0)   begin errors++; $display("FAIL reset_tx_start: got %0b want 0", bus.tx_start); end
        checks++; if (bus.tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %0h want 00", bus.tx_data); end
        checks++; if (bus.grant !== 2'b00)     begin errors++; $display("FAIL reset_grant: got %0b want 00", bus.grant); end
        checks++; if (bus.err_timeout !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", bus.err_timeout); end
        checks++; if (bus.byte_cnt !== 16'h0)  begin errors++; $display("FAIL reset_byte_cnt: got %0h want 0", bus.byte_cnt); end
        checks++; if (rdy0_cnt != 0 || bus.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %0d cycles want 0", rdy0_cnt); end
        resetn = 1'b1;
        rel = cyc;
        wait_tx(1, 10);
        checks++;
        if (tx_log.size() < 1 || tx_log[0] !== 8'hAA || tx_cyc[0] != rel + 1) begin
            errors++;
            $display("FAIL first_after_reset: got %0d starts want AA at cycle %0d", tx_log.size(), rel + 1);
        end
    endtask

    task automatic test_single();
        apply_reset();
        q0.push_back({1'b1, 8'hA5});
        wait_cnt(16'd1, 40);
        checks++; if (bus.byte_cnt !== 16'd1) begin errors++; $display("FAIL single_byte_cnt: got %0h want 1", bus.byte_cnt); end
        checks++; if (rdy0_cnt != 1) begin errors++; $display("FAIL single_ready_cycles: got %0d want 1", rdy0_cnt); end
        checks++;
        if (tx_log.size() != 1 || tx_log[0] !== 8'hA5 || tx_cyc[0] != rdy0_cyc + 1) begin
            errors++;
            $display("FAIL single_tx: got %0d starts want 1 start of A5 at cycle %0d", tx_log.size(), rdy0_cyc + 1);
        end
        checks++; if (tx_log.size() == 1 && tx_grant[0] !== 2'b01) begin errors++; $display("FAIL single_grant_busy: got %0b want 01", tx_grant[0]); end
        checks++; if (tx_cyc.size() == 1 && cyc != tx_cyc[0] + 12) begin errors++; $display("FAIL single_done_latency: got cycle %0d want %0d", cyc, tx_cyc[0] + 12); end
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL single_grant_idle: got %0b want 00", bus.grant); end
        checks++; if (bus.tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data_hold: got %0h want A5", bus.tx_data); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [4];
        logic [1:0] exp_g [4];
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h11; exp_d[3] = 8'h22;
        exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
        apply_reset();
        busy_len = 2;
        q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h11});
        q1.push_back({1'b1, 8'h22}); q1.push_back({1'b1, 8'h22});
        wait_cnt(16'd4, 100);
        checks++; if (tx_log.size() != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", tx_log.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < tx_log.size()) begin
                checks++;
                if (tx_log[i] !== exp_d[i] || tx_grant[i] !== exp_g[i]) begin
                    errors++;
                    $display("FAIL rr_order[%0d]: got %0h/%0b want %0h/%0b", i, tx_log[i], tx_grant[i], exp_d[i], exp_g[i]);
                end
            end
        end
    endtask

    task automatic test_packet_lock();
        int blocked = 0;
        int bad_grant = 0;
        int n = 0;
        logic [7:0] exp_d [4];
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h22;
        apply_reset();
        busy_len = 3;
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b0, 8'h02}); q0.push_back({1'b1, 8'h03});
        q1.push_back({1'b1, 8'h22});
        while (bus.byte_cnt !== 16'd4 && n < 200) begin
            tick();
            n++;
            if (bus.byte_cnt < 16'd3 && bus.req1_ready === 1'b1) blocked++;
            if (tx_log.size() >= 1 && bus.byte_cnt < 16'd3 && bus.grant !== 2'b01) bad_grant++;
        end
        checks++; if (bus.byte_cnt !== 16'd4) begin errors++; $display("FAIL lock_done: got %0h want 4", bus.byte_cnt); end
        checks++; if (blocked != 0) begin errors++; $display("FAIL lock_req1_blocked: got %0d ready cycles want 0", blocked); end
        checks++; if (bad_grant != 0) begin errors++; $display("FAIL lock_grant: got %0d cycles off 01 want 0", bad_grant); end
        for (int i = 0; i < 4; i++) begin
            if (i < tx_log.size()) begin
                checks++;
                if (tx_log[i] !== exp_d[i]) begin
                    errors++;
                    $display("FAIL lock_order[%0d]: got %0h want %0h", i, tx_log[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_watchdog();
        int n = 0;
        apply_reset();
        busy_en = 1'b0;
        q0.push_back({1'b0, 8'h5A});
        while (err_cyc.size() < 1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (err_cyc.size() < 1 || tx_cyc.size() < 1 || err_cyc[0] - tx_cyc[0] != 16) begin
            errors++;
            $display("FAIL wd_latency: got %0d pulses want 1 at tx_start+16", err_cyc.size());
        end
        tick(); tick();
        checks++; if (err_cyc.size() != 1) begin errors++; $display("FAIL wd_pulse_width: got %0d pulses want 1", err_cyc.size()); end
        checks++; if (bus.byte_cnt !== 16'd0) begin errors++; $display("FAIL wd_byte_cnt: got %0h want 0", bus.byte_cnt); end
        checks++; if (bus.grant !== 2'b00) begin errors++; $display("FAIL wd_lock_cleared: got grant %0b want 00", bus.grant); end
        busy_en  = 1'b1;
        busy_len = 2;
        q1.push_back({1'b1, 8'h33});
        wait_cnt(16'd1, 40);
        checks++;
        if (tx_log.size() != 2 || tx_log[1] !== 8'h33) begin
            errors++;
            $display("FAIL wd_req1_after: got %0d starts want 2 ending with 33", tx_log.size());
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        q0.push_back({1'b0, 8'h77});
        wait_tx(1, 10);
        repeat (3) tick();
        q1.push_back({1'b1, 8'h44});
        tick();
        #2;
        resetn   = 1'b0;
        busy_cnt = 0;
        bus.tx_busy = 1'b0;
        #1;
        checks++;
        if (bus.tx_start !== 1'b0 || bus.tx_data !== 8'h00 || bus.grant !== 2'b00 ||
            bus.err_timeout !== 1'b0 || bus.byte_cnt !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got start=%0b data=%0h grant=%0b err=%0b cnt=%0h want all 0",
                     bus.tx_start, bus.tx_data, bus.grant, bus.err_timeout, bus.byte_cnt);
        end
        tick();
        checks++;
        if (bus.req1_valid !== 1'b1 || bus.req1_ready !== 1'b0 || bus.req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_ready: got r0=%0b r1=%0b v1=%0b want 0/0/1",
                     bus.req0_ready, bus.req1_ready, bus.req1_valid);
        end
        q0.delete(); q1.delete();
        tick(); tick();
        resetn = 1'b1;
        repeat (20) tick();
        checks++; if (tx_log.size() != 1) begin errors++; $display("FAIL mid_reset_spurious: got %0d starts want 1", tx_log.size()); end
        checks++; if (bus.byte_cnt !== 16'h0) begin errors++; $display("FAIL mid_reset_cnt: got %0h want 0", bus.byte_cnt); end
    endtask

    task automatic test_wrap();
        apply_reset();
        busy_len = 2;
        force dut.byte_cnt_q = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.byte_cnt_q;
        tick();
        checks++; if (bus.byte_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %0h want FFFF", bus.byte_cnt); end
        q0.push_back({1'b1, 8'hC3});
        wait_cnt(16'h0000, 30);
        checks++; if (bus.byte_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt: got %0h want 0000", bus.byte_cnt); end
        checks++; if (tx_log.size() != 1 || tx_log[0] !== 8'hC3) begin errors++; $display("FAIL wrap_tx: got %0d starts want 1 of C3", tx_log.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_packet_lock();
        test_watchdog();
        test_reset_mid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
